// File: rtl/mii_rx_deframer.sv
// mii_rx_deframer
//   Receive deframer for a 64-bit / 8-lane MII link. Removes the Start,
//   preamble and SFD word at the head of each frame and the Terminate and
//   idle bytes at the tail. Delivers the payload as a beat stream with a
//   per-byte keep mask, a last flag and an error flag. Keeps wrapping
//   counters of good frames and of errored or dropped frames. There is no
//   backpressure because the MII link cannot stall.
//
// Ports
//   clk          rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_rx_data    MII data, lane n = bits [8n+7:8n]
//   i_rx_ctrl    MII control, bit n marks lane n as a control character
//   o_data       payload word (zero when o_valid=0)
//   o_keep       valid-byte mask, contiguous from lane 0 (zero when o_valid=0)
//   o_valid      beat strobe, one cycle per beat
//   o_last       final beat of a frame
//   o_err        frame ended abnormally (qualifies o_last)
//   o_frame_cnt  good frames received
//   o_err_cnt    errored or dropped frames
//   o_dbg_state  current FSM state: 0 idle, 1 data, 2 drop
//
// Output stream contract: there is no ready signal. A beat exists exactly
// in the cycles where o_valid=1, and the consumer must take it in that cycle.
module mii_rx_deframer #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int MAX_WORDS  = 190,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CTRL_WIDTH-1:0] o_keep,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  o_err,
  output logic [CNT_WIDTH-1:0]  o_frame_cnt,
  output logic [CNT_WIDTH-1:0]  o_err_cnt,
  output logic [1:0]            o_dbg_state
);

  localparam int LANES  = CTRL_WIDTH;
  localparam int WCNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WORDS);

  localparam logic [7:0] CH_IDLE  = 8'h07;
  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_PRE   = 8'h55;
  localparam logic [7:0] CH_SFD   = 8'hD5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic                    pend_q, pend_d;
  logic [DATA_WIDTH-1:0]   pend_data_q, pend_data_d;
  logic [CTRL_WIDTH-1:0]   pend_keep_q, pend_keep_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CTRL_WIDTH-1:0]   keep_q, keep_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    err_q, err_d;
  logic [CNT_WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;

  // Word classification
  logic                    is_data, is_start, start_ok, has_t, all_idle;
  logic                    is_term, term_ok;
  logic [2:0]              term_k;
  logic [DATA_WIDTH-1:0]   part_data;
  logic [CTRL_WIDTH-1:0]   part_keep;

  always_comb begin
    is_data  = (i_rx_ctrl == '0);
    is_start = (i_rx_ctrl == 8'h01) && (i_rx_data[7:0] == CH_START);
    start_ok = is_start && (i_rx_data[63:8] == {CH_SFD, {6{CH_PRE}}});
    has_t    = 1'b0;
    all_idle = (i_rx_ctrl == '1);
    is_term  = 1'b0;
    term_ok  = 1'b0;
    term_k   = '0;
    for (int n = 0; n < LANES; n++) begin
      if (i_rx_ctrl[n] && (i_rx_data[8*n +: 8] == CH_TERM)) has_t = 1'b1;
      if (i_rx_data[8*n +: 8] != CH_IDLE) all_idle = 1'b0;
    end
    // A well-formed Terminate: data below lane k, T in lane k, idles above.
    for (int k = 0; k < LANES; k++) begin
      term_ok = (i_rx_ctrl == ~((CTRL_WIDTH'(1) << k) - CTRL_WIDTH'(1))) &&
                (i_rx_data[8*k +: 8] == CH_TERM);
      for (int n = 0; n < LANES; n++) begin
        if ((n > k) && (i_rx_data[8*n +: 8] != CH_IDLE)) term_ok = 1'b0;
      end
      if (term_ok) begin
        is_term = 1'b1;
        term_k  = 3'(k);
      end
    end
    part_keep = (CTRL_WIDTH'(1) << term_k) - CTRL_WIDTH'(1);
    part_data = '0;
    for (int n = 0; n < LANES; n++) begin
      if (n < int'(term_k)) part_data[8*n +: 8] = i_rx_data[8*n +: 8];
    end
  end

  // Next state, hold register and output beat
  logic       close_err;
  logic       frame_inc;
  logic [1:0] err_inc;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    wcnt_d      = wcnt_q;
    pend_d      = 1'b0;
    pend_data_d = '0;
    pend_keep_d = '0;
    data_d      = '0;
    keep_d      = '0;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    err_d       = 1'b0;
    close_err   = 1'b0;
    frame_inc   = 1'b0;
    err_inc     = 2'd0;

    // Partial beat left over from a Terminate in lane 1..7. The FSM is
    // already in IDLE, so this overlaps normal processing of the new word.
    if (pend_q) begin
      valid_d   = 1'b1;
      last_d    = 1'b1;
      data_d    = pend_data_q;
      keep_d    = pend_keep_q;
      frame_inc = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d     = S_DATA;
          wcnt_d      = '0;
          hold_full_d = 1'b0;
        end else if (is_start) begin
          err_inc = 2'd1;
        end
      end
      S_DATA: begin
        if (is_start) begin
          // Abort the running frame, then handle the word as a new Start.
          close_err = 1'b1;
          if (start_ok) begin
            err_inc = 2'd1;
            wcnt_d  = '0;
          end else begin
            err_inc = 2'd2;
            state_d = S_IDLE;
          end
        end else if (is_data) begin
          if (wcnt_q == WCNT_MAX) begin
            close_err = 1'b1;
            err_inc   = 2'd1;
            state_d   = S_DROP;
          end else begin
            if (hold_full_q) begin
              valid_d = 1'b1;
              data_d  = hold_q;
              keep_d  = '1;
            end
            hold_d      = i_rx_data;
            hold_full_d = 1'b1;
            wcnt_d      = wcnt_q + WCNT_W'(1);
          end
        end else if (is_term) begin
          state_d     = S_IDLE;
          hold_full_d = 1'b0;
          if (term_k == '0) begin
            if (hold_full_q) begin
              valid_d   = 1'b1;
              last_d    = 1'b1;
              data_d    = hold_q;
              keep_d    = '1;
              frame_inc = 1'b1;
            end else begin
              err_inc = 2'd1;
            end
          end else begin
            if (hold_full_q) begin
              valid_d = 1'b1;
              data_d  = hold_q;
              keep_d  = '1;
            end
            pend_d      = 1'b1;
            pend_data_d = part_data;
            pend_keep_d = part_keep;
          end
        end else begin
          close_err = 1'b1;
          err_inc   = 2'd1;
          state_d   = has_t ? S_IDLE : S_DROP;
        end
      end
      S_DROP: begin
        if (has_t || all_idle) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Error close: flush the hold word, or an empty beat if nothing is held,
    // so the consumer always sees a last+err marker.
    if (close_err) begin
      valid_d     = 1'b1;
      last_d      = 1'b1;
      err_d       = 1'b1;
      data_d      = hold_full_q ? hold_q : '0;
      keep_d      = hold_full_q ? '1 : '0;
      hold_full_d = 1'b0;
    end

    frame_cnt_d = frame_cnt_q + CNT_WIDTH'(frame_inc);
    err_cnt_d   = err_cnt_q + CNT_WIDTH'(err_inc);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      wcnt_q      <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_keep_q <= '0;
      data_q      <= '0;
      keep_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      wcnt_q      <= wcnt_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_keep_q <= pend_keep_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_data      = data_q;
  assign o_keep      = keep_q;
  assign o_valid     = valid_q;
  assign o_last      = last_q;
  assign o_err       = err_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Bench for mii_rx_deframer. Frames are described by their payload bytes and
// ending kind; the expected beat list and counter totals are derived from
// that description, not from any cycle-level model of the deframer.
module tb_mii_rx_deframer;

  localparam int MAXW = 6;
  localparam int EW   = 64 + 8 + 1 + 1;   // {data, keep, last, err}

  localparam int K_GOOD  = 0;
  localparam int K_ERRW  = 1;
  localparam int K_ABORT = 2;
  localparam int K_BADST = 3;

  localparam logic [63:0] IDLE_W  = {8{8'h07}};
  localparam logic [63:0] START_W = {8'hD5, {6{8'h55}}, 8'hFB};

  logic        clk;
  logic        i_rst_n;
  logic [63:0] i_rx_data;
  logic [7:0]  i_rx_ctrl;
  logic [63:0] o_data;
  logic [7:0]  o_keep;
  logic        o_valid;
  logic        o_last;
  logic        o_err;
  logic [31:0] o_frame_cnt;
  logic [31:0] o_err_cnt;
  logic [1:0]  o_dbg_state;

  mii_rx_deframer #(.MAX_WORDS(MAXW)) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_rx_data   (i_rx_data),
    .i_rx_ctrl   (i_rx_ctrl),
    .o_data      (o_data),
    .o_keep      (o_keep),
    .o_valid     (o_valid),
    .o_last      (o_last),
    .o_err       (o_err),
    .o_frame_cnt (o_frame_cnt),
    .o_err_cnt   (o_err_cnt),
    .o_dbg_state (o_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  logic [7:0]    pay[$];
  logic [31:0]   frame_m, err_m;
  int            n_checks, n_pass;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic e);
    exp_q.push_back({d, k, l, e});
  endtask

  always @(negedge clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) chk("beat_extra", o_valid, 1'b0);
      else chk("beat", {o_data, o_keep, o_last, o_err}, exp_q.pop_front());
    end else begin
      chk("idle_zero", {o_data, o_keep, o_last, o_err}, '0);
    end
  end

  task automatic chk_counts();
    chk("frame_cnt", o_frame_cnt, frame_m);
    chk("err_cnt", o_err_cnt, err_m);
  endtask

  // Driver tasks
  task automatic send_word(input logic [63:0] d, input logic [7:0] c);
    i_rx_data = d;
    i_rx_ctrl = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_idle();
    send_word(IDLE_W, 8'hFF);
  endtask

  function automatic logic [63:0] pay_word(input int w);
    logic [63:0] r;
    for (int n = 0; n < 8; n++) r[8*n +: 8] = pay[8*w + n];
    return r;
  endfunction

  task automatic send_frame(input int kind, input int len);
    int          f, rem, j;
    logic [63:0] w;
    logic [7:0]  c;
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
    f   = len / 8;
    rem = len % 8;

    // Expected outcome of the frame
    case (kind)
      K_GOOD: begin
        if (f > MAXW) begin
          for (int i = 0; i < MAXW; i++)
            push_beat(pay_word(i), 8'hFF, i == MAXW - 1, i == MAXW - 1);
          err_m++;
        end else begin
          for (int i = 0; i < f; i++)
            push_beat(pay_word(i), 8'hFF, (rem == 0) && (i == f - 1), 1'b0);
          if (rem != 0) begin
            w = '0;
            for (int n = 0; n < rem; n++) w[8*n +: 8] = pay[8*f + n];
            push_beat(w, 8'((1 << rem) - 1), 1'b1, 1'b0);
            frame_m++;
          end else if (f == 0) begin
            err_m++;
          end else begin
            frame_m++;
          end
        end
      end
      K_ERRW, K_ABORT: begin
        for (int i = 0; i < f; i++) push_beat(pay_word(i), 8'hFF, i == f - 1, i == f - 1);
        if (f == 0) push_beat('0, '0, 1'b1, 1'b1);
        err_m++;
      end
      default: err_m++;   // bad Start: whole frame ignored
    endcase

    // Drive the words
    w = START_W;
    if (kind == K_BADST) begin
      j = $urandom_range(1, 7);
      w[8*j +: 8] = w[8*j +: 8] ^ 8'($urandom_range(1, 255));
    end
    send_word(w, 8'h01);
    for (int i = 0; i < f; i++) send_word(pay_word(i), 8'h00);
    if (kind == K_GOOD || kind == K_BADST) begin
      w = IDLE_W;
      for (int n = 0; n < rem; n++) w[8*n +: 8] = pay[8*f + n];
      w[8*rem +: 8] = 8'hFD;
      send_word(w, ~8'((1 << rem) - 1));
    end else if (kind == K_ERRW) begin
      j = $urandom_range(1, 7);
      w = {$urandom, $urandom};
      w[8*j +: 8] = 8'hFE;
      send_word(w, 8'(1 << j));
    end
  endtask

  // Main sequence
  initial begin
    int kind, len, gap, sel;
    n_checks  = 0;
    n_pass    = 0;
    frame_m   = '0;
    err_m     = '0;
    i_rx_data = IDLE_W;
    i_rx_ctrl = 8'hFF;
    i_rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", o_valid, 1'b0);
    chk_counts();

    // Three-word frame, T in lane 0; first beat one edge after next word
    push_beat({8{8'h11}}, 8'hFF, 1'b0, 1'b0);
    push_beat({8{8'h22}}, 8'hFF, 1'b0, 1'b0);
    push_beat({8{8'h33}}, 8'hFF, 1'b1, 1'b0);
    send_word(START_W, 8'h01);
    send_word({8{8'h11}}, 8'h00);
    send_word({8{8'h22}}, 8'h00);
    @(negedge clk);
    chk("lat_first_beat", o_valid, 1'b1);
    send_word({8{8'h33}}, 8'h00);
    send_word({{7{8'h07}}, 8'hFD}, 8'hFF);
    frame_m++;
    send_idle();
    send_idle();
    chk_counts();

    // One word then T in lane 3 carrying AA BB CC
    push_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 1'b0);
    push_beat(64'h0000_0000_00CC_BBAA, 8'h07, 1'b1, 1'b0);
    send_word(START_W, 8'h01);
    send_word(64'h0123_4567_89AB_CDEF, 8'h00);
    send_word(64'h0707_0707_FDCC_BBAA, 8'hF8);
    @(negedge clk);
    chk("t3_hold_not_last", o_last, 1'b0);
    send_idle();
    @(negedge clk);
    chk("t3_partial_keep", o_keep, 8'h07);
    frame_m++;
    send_idle();
    chk_counts();

    // Reset in mid-frame: beats already emitted stand, the rest vanishes
    push_beat({8{8'hA1}}, 8'hFF, 1'b0, 1'b0);
    push_beat({8{8'hA2}}, 8'hFF, 1'b0, 1'b0);
    send_word(START_W, 8'h01);
    send_word({8{8'hA1}}, 8'h00);
    send_word({8{8'hA2}}, 8'h00);
    send_word({8{8'hA3}}, 8'h00);
    @(negedge clk);
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", o_valid, 1'b0);
    chk("rst_mid_frame_cnt", o_frame_cnt, 32'd0);
    chk("rst_mid_err_cnt", o_err_cnt, 32'd0);
    frame_m = '0;
    err_m   = '0;
    i_rx_data = IDLE_W;
    i_rx_ctrl = 8'hFF;
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;
    send_idle();

    // Random frames
    for (int t = 0; t < 80; t++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      kind = K_GOOD;
      else if (sel == 6) kind = K_ERRW;
      else if (sel == 7) kind = K_ABORT;
      else               kind = K_BADST;
      if (kind == K_ERRW || kind == K_ABORT) len = 8 * $urandom_range(0, MAXW);
      else len = $urandom_range(0, 8 * (MAXW + 2) + 7);
      send_frame(kind, len);
      if (kind == K_ABORT)     gap = 0;
      else if (kind == K_ERRW) gap = 1 + $urandom_range(0, 2);
      else                     gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) send_idle();
      if (gap >= 1) chk_counts();
    end

    repeat (3) send_idle();
    chk_counts();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
